// File: rtl/rpn_calc.sv
// rpn_calc: 16-bit Reverse Polish Notation calculator on a small register stack.
// Four active-low pushbuttons select an operation from the bank picked by mode.
// Only the falling edge of a key acts. When several keys fall on the same edge,
// the lowest-numbered key wins.
// Optional macro RPN_MUL_EN: enables the 16x16 multiply (low 16 bits) on mode 01 KEY2.
// When the macro is undefined, that key is a no-op.
module rpn_calc #(
    parameter int DEPTH = 8
) (
    input  logic        clk2,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [3:0]  key,
    input  logic [15:0] val,
    output logic [15:0] top,
    output logic [15:0] next,
    output logic [7:0]  counter
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [7:0]  DEPTH_C = 8'(DEPTH);

    logic [15:0]   s_q [DEPTH];
    logic [15:0]   s_d [DEPTH];
    logic [7:0]    d_q;
    logic [7:0]    d_d;
    logic [3:0]    key_prev_q;

    logic [3:0]    fall_s;
    logic          any_s;
    logic [1:0]    sel_s;
    logic [AW-1:0] push_idx_s;
    logic [AW-1:0] tidx_s;
    logic [AW-1:0] nidx_s;
    logic          has1_s;
    logic          has2_s;
    logic          full_s;
    logic [15:0]   top_s;
    logic [15:0]   next_s;
`ifdef RPN_MUL_EN
    logic [15:0]   mul_s;
`endif

    // Lowest-index key among the simultaneous falling edges.
    function automatic logic [1:0] lowest_key(input logic [3:0] v);
        logic [1:0] r;
        if (v[0])      r = 2'd0;
        else if (v[1]) r = 2'd1;
        else if (v[2]) r = 2'd2;
        else           r = 2'd3;
        return r;
    endfunction

    assign fall_s     = key_prev_q & ~key;
    assign any_s      = |fall_s;
    assign sel_s      = lowest_key(fall_s);
    // The low bits of the depth wrap modulo the array size, so d-1 and d-2 index correctly even when d equals DEPTH.
    assign push_idx_s = d_q[AW-1:0];
    assign tidx_s     = d_q[AW-1:0] - AW'(1);
    assign nidx_s     = d_q[AW-1:0] - AW'(2);
    assign has1_s     = (d_q != 8'd0);
    assign has2_s     = (d_q >= 8'd2);
    assign full_s     = (d_q == DEPTH_C);
    assign top_s      = s_q[tidx_s];
    assign next_s     = s_q[nidx_s];
`ifdef RPN_MUL_EN
    assign mul_s      = next_s * top_s;
`endif

    assign top     = has1_s ? top_s  : 16'h0000;
    assign next    = has2_s ? next_s : 16'h0000;
    assign counter = d_q;

    // Next-state stack contents and depth for the key action, or hold when no action is valid.
    always_comb begin
        s_d = s_q;
        d_d = d_q;
        if (any_s) begin
            case ({mode, sel_s})
                4'b00_00: if (!full_s) begin s_d[push_idx_s] = val;    d_d = d_q + 8'd1; end
                          else         begin d_d = d_q; end
                4'b00_01: if (has1_s)  begin d_d = d_q - 8'd1; end
                          else         begin d_d = d_q; end
                4'b00_10: begin d_d = 8'd0; end
                4'b00_11: if (has1_s && !full_s) begin s_d[push_idx_s] = top_s; d_d = d_q + 8'd1; end
                          else         begin d_d = d_q; end
                4'b01_00: if (has2_s)  begin s_d[nidx_s] = next_s + top_s; d_d = d_q - 8'd1; end
                          else         begin d_d = d_q; end
                4'b01_01: if (has2_s)  begin s_d[nidx_s] = next_s - top_s; d_d = d_q - 8'd1; end
                          else         begin d_d = d_q; end
`ifdef RPN_MUL_EN
                4'b01_10: if (has2_s)  begin s_d[nidx_s] = mul_s;           d_d = d_q - 8'd1; end
                          else         begin d_d = d_q; end
`else
                4'b01_10: begin d_d = d_q; end
`endif
                4'b01_11: if (has2_s)  begin s_d[nidx_s] = top_s; s_d[tidx_s] = next_s; end
                          else         begin d_d = d_q; end
                4'b10_00: if (has2_s)  begin s_d[nidx_s] = next_s & top_s; d_d = d_q - 8'd1; end
                          else         begin d_d = d_q; end
                4'b10_01: if (has2_s)  begin s_d[nidx_s] = next_s | top_s; d_d = d_q - 8'd1; end
                          else         begin d_d = d_q; end
                4'b10_10: if (has2_s)  begin s_d[nidx_s] = next_s ^ top_s; d_d = d_q - 8'd1; end
                          else         begin d_d = d_q; end
                4'b10_11: if (has1_s)  begin s_d[tidx_s] = ~top_s; end
                          else         begin d_d = d_q; end
                4'b11_00: if (has1_s)  begin s_d[tidx_s] = val; end
                          else         begin d_d = d_q; end
                default:  begin d_d = d_q; end
            endcase
        end else begin
            d_d = d_q;
        end
    end

    // Stack, depth and key history registers. Reset overrides any key event on the same edge.
    always_ff @(posedge clk2) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) s_q[i] <= 16'h0000;
            d_q        <= 8'd0;
            key_prev_q <= 4'b1111;
        end else begin
            s_q        <= s_d;
            d_q        <= d_d;
            key_prev_q <= key;
        end
    end

endmodule

// File: tb/tb_rpn_calc.sv
// Directed self-checking bench for rpn_calc (DEPTH = 8).
module tb_rpn_calc;

    logic        clk2;
    logic        rst;
    logic [1:0]  mode;
    logic [3:0]  key;
    logic [15:0] val;
    logic [15:0] top;
    logic [15:0] next;
    logic [7:0]  counter;

    int checks = 0;
    int errors = 0;

    rpn_calc #(.DEPTH(8)) dut (
        .clk2(clk2), .rst(rst), .mode(mode), .key(key), .val(val),
        .top(top), .next(next), .counter(counter)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    // One press: drive at negedge, release next negedge, idle one more cycle.
    task automatic press(input logic [1:0] m, input int idx, input logic [15:0] v);
        logic [3:0] k;
        k = 4'b1111;
        k[idx] = 1'b0;
        @(negedge clk2);
        mode = m; val = v; key = k;
        @(negedge clk2);
        key = 4'b1111;
        @(negedge clk2);
    endtask

    task automatic clear_stack();
        press(2'b00, 2, 16'h0000);
    endtask

    task automatic test_reset();
        rst = 1'b0; key = 4'b1111; mode = 2'b00; val = 16'h0000;
        repeat (3) @(negedge clk2);
        rst = 1'b1;
        repeat (2) @(negedge clk2);
        checks++;
        if ({top, next, counter} !== {16'h0000, 16'h0000, 8'h00}) begin
            errors++;
            $display("FAIL reset: got top=%h next=%h cnt=%h want 0000 0000 00", top, next, counter);
        end
    endtask

    task automatic test_push();
        press(2'b00, 0, 16'h0005);
        checks++;
        if ({top, next, counter} !== {16'h0005, 16'h0000, 8'h01}) begin
            errors++;
            $display("FAIL push1: got top=%h next=%h cnt=%h want 0005 0000 01", top, next, counter);
        end
        press(2'b00, 0, 16'h0003);
        checks++;
        if ({top, next, counter} !== {16'h0003, 16'h0005, 8'h02}) begin
            errors++;
            $display("FAIL push2: got top=%h next=%h cnt=%h want 0003 0005 02", top, next, counter);
        end
    endtask

    task automatic test_sub();
        press(2'b01, 1, 16'h0000);
        checks++;
        if ({top, next, counter} !== {16'h0002, 16'h0000, 8'h01}) begin
            errors++;
            $display("FAIL sub: got top=%h next=%h cnt=%h want 0002 0000 01", top, next, counter);
        end
        clear_stack();
        press(2'b00, 0, 16'h0001);
        press(2'b00, 0, 16'h0002);
        press(2'b01, 1, 16'h0000);
        checks++;
        if ({top, counter} !== {16'hFFFF, 8'h01}) begin
            errors++;
            $display("FAIL sub_wrap: got top=%h cnt=%h want FFFF 01", top, counter);
        end
    endtask

    task automatic test_add_swap_dup();
        clear_stack();
        press(2'b00, 0, 16'hFFFF);
        press(2'b00, 0, 16'h0003);
        press(2'b01, 3, 16'h0000);
        checks++;
        if ({top, next, counter} !== {16'hFFFF, 16'h0003, 8'h02}) begin
            errors++;
            $display("FAIL swap: got top=%h next=%h cnt=%h want FFFF 0003 02", top, next, counter);
        end
        press(2'b01, 0, 16'h0000);
        checks++;
        if ({top, next, counter} !== {16'h0002, 16'h0000, 8'h01}) begin
            errors++;
            $display("FAIL add_wrap: got top=%h next=%h cnt=%h want 0002 0000 01", top, next, counter);
        end
        press(2'b00, 3, 16'h0000);
        checks++;
        if ({top, next, counter} !== {16'h0002, 16'h0002, 8'h02}) begin
            errors++;
            $display("FAIL dup: got top=%h next=%h cnt=%h want 0002 0002 02", top, next, counter);
        end
        press(2'b11, 0, 16'h1234);
        checks++;
        if ({top, next, counter} !== {16'h1234, 16'h0002, 8'h02}) begin
            errors++;
            $display("FAIL load: got top=%h next=%h cnt=%h want 1234 0002 02", top, next, counter);
        end
    endtask

    task automatic test_logic();
        clear_stack();
        press(2'b00, 0, 16'h00FF);
        press(2'b00, 0, 16'h0F0F);
        press(2'b10, 0, 16'h0000);
        checks++;
        if ({top, counter} !== {16'h000F, 8'h01}) begin
            errors++;
            $display("FAIL and: got top=%h cnt=%h want 000F 01", top, counter);
        end
        press(2'b10, 3, 16'h0000);
        checks++;
        if ({top, counter} !== {16'hFFF0, 8'h01}) begin
            errors++;
            $display("FAIL not: got top=%h cnt=%h want FFF0 01", top, counter);
        end
        press(2'b00, 0, 16'h0F0F);
        press(2'b10, 2, 16'h0000);
        checks++;
        if ({top, counter} !== {16'hF0FF, 8'h01}) begin
            errors++;
            $display("FAIL xor: got top=%h cnt=%h want F0FF 01", top, counter);
        end
        press(2'b00, 0, 16'h0F00);
        press(2'b10, 1, 16'h0000);
        checks++;
        if ({top, counter} !== {16'hFFFF, 8'h01}) begin
            errors++;
            $display("FAIL or: got top=%h cnt=%h want FFFF 01", top, counter);
        end
    endtask

    task automatic test_mul();
        logic [15:0] exp_top;
        logic [7:0]  exp_cnt;
        clear_stack();
        press(2'b00, 0, 16'h0003);
        press(2'b00, 0, 16'h0004);
        press(2'b01, 2, 16'h0000);
`ifdef RPN_MUL_EN
        exp_top = 16'h000C; exp_cnt = 8'h01;
`else
        exp_top = 16'h0004; exp_cnt = 8'h02;
`endif
        checks++;
        if ({top, counter} !== {exp_top, exp_cnt}) begin
            errors++;
            $display("FAIL mul: got top=%h cnt=%h want %h %h", top, counter, exp_top, exp_cnt);
        end
    endtask

    task automatic test_boundaries();
        clear_stack();
        for (int i = 1; i <= 9; i++) press(2'b00, 0, 16'(i));
        checks++;
        if ({top, next, counter} !== {16'h0008, 16'h0007, 8'h08}) begin
            errors++;
            $display("FAIL overflow: got top=%h next=%h cnt=%h want 0008 0007 08", top, next, counter);
        end
        clear_stack();
        press(2'b00, 1, 16'h0000);
        checks++;
        if ({top, next, counter} !== {16'h0000, 16'h0000, 8'h00}) begin
            errors++;
            $display("FAIL underflow: got top=%h next=%h cnt=%h want 0000 0000 00", top, next, counter);
        end
        press(2'b00, 0, 16'h0007);
        press(2'b01, 0, 16'h0000);
        checks++;
        if ({top, next, counter} !== {16'h0007, 16'h0000, 8'h01}) begin
            errors++;
            $display("FAIL binop_d1: got top=%h next=%h cnt=%h want 0007 0000 01", top, next, counter);
        end
    endtask

    task automatic test_hold_and_multi();
        clear_stack();
        @(negedge clk2);
        mode = 2'b00; val = 16'h0AAA; key = 4'b1110;
        repeat (10) @(negedge clk2);
        key = 4'b1111;
        @(negedge clk2);
        checks++;
        if ({top, counter} !== {16'h0AAA, 8'h01}) begin
            errors++;
            $display("FAIL hold: got top=%h cnt=%h want 0AAA 01", top, counter);
        end
        @(negedge clk2);
        val = 16'h0022; key = 4'b1100;
        @(negedge clk2);
        key = 4'b1111;
        @(negedge clk2);
        checks++;
        if ({top, next, counter} !== {16'h0022, 16'h0AAA, 8'h02}) begin
            errors++;
            $display("FAIL multi_key: got top=%h next=%h cnt=%h want 0022 0AAA 02", top, next, counter);
        end
        mode = 2'b01; val = 16'h5555;
        repeat (3) @(negedge clk2);
        checks++;
        if ({top, next, counter} !== {16'h0022, 16'h0AAA, 8'h02}) begin
            errors++;
            $display("FAIL idle_change: got top=%h next=%h cnt=%h want 0022 0AAA 02", top, next, counter);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk2);
        mode = 2'b00; val = 16'h0033; key = 4'b1110; rst = 1'b0;
        @(negedge clk2);
        checks++;
        if ({top, next, counter} !== {16'h0000, 16'h0000, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid: got top=%h next=%h cnt=%h want 0000 0000 00", top, next, counter);
        end
        key = 4'b1111;
        @(negedge clk2);
        rst = 1'b1;
        repeat (2) @(negedge clk2);
        press(2'b00, 0, 16'h0044);
        checks++;
        if ({top, next, counter} !== {16'h0044, 16'h0000, 8'h01}) begin
            errors++;
            $display("FAIL after_reset: got top=%h next=%h cnt=%h want 0044 0000 01", top, next, counter);
        end
    endtask

    initial begin
        test_reset();
        test_push();
        test_sub();
        test_add_swap_dup();
        test_logic();
        test_mul();
        test_boundaries();
        test_hold_and_multi();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
